// File: rtl/vec_lsu.sv
// vec_lsu: vector load/store unit feeding the vector ALU.
//
// A load gathers VL elements of SEW bits from a 32-bit word memory port and
// presents them as one VL*SEW-bit operand; a store serialises a VL*SEW-bit
// vector back to memory. Element i lives at base + i*stride (mod 2^32).
// One vector request is handled at a time; element issue overlaps with
// in-order load returns.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         vector request handshake (ready only in IDLE)
//   req_store                   1 = store, 0 = load
//   req_base, req_stride        byte address of element 0, signed byte stride
//   req_data                    store data, element i at [i*SEW +: SEW]
//   mem_valid/mem_ready         memory request handshake
//   mem_we, mem_addr, mem_wdata write enable, byte address, write data
//   mem_rvalid, mem_rdata       in-order read return, no backpressure
//   resp_valid/resp_ready       completion handshake
//   resp_store                  completed operation was a store
//   resp_data                   load result, element i at [i*SEW +: SEW]
module vec_lsu #(
    parameter int VL  = 8,
    parameter int SEW = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [31:0]       req_base,
    input  logic [31:0]       req_stride,
    input  logic [VL*SEW-1:0] req_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_store,
    output logic [VL*SEW-1:0] resp_data
);

    // One extra bit so the counters can hold VL itself.
    localparam int CW = $clog2(VL) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(VL - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [CW-1:0]       issue_cnt_r;
    logic [CW-1:0]       ret_cnt_r;
    logic [31:0]         addr_r;
    logic [31:0]         stride_r;
    logic                store_r;
    logic [VL*SEW-1:0]   wdata_r;
    logic [VL*SEW-1:0]   resp_data_r;
    logic                accept_s;
    logic                issue_fire_s;
    logic                ret_fire_s;

    // Next-state logic and per-cycle handshake strobes.
    always_comb begin
        state_s      = state_r;
        accept_s     = 1'b0;
        issue_fire_s = 1'b0;
        ret_fire_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    state_s  = ST_ISSUE;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                issue_fire_s = mem_ready;
                ret_fire_s   = mem_rvalid & ~store_r;
                // A final load return can coincide with the final issue.
                if (ret_fire_s && (ret_cnt_r == CNT_LAST)) begin
                    state_s = ST_RESP;
                end else if (issue_fire_s && (issue_cnt_r == CNT_LAST)) begin
                    state_s = store_r ? ST_RESP : ST_WAIT;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                ret_fire_s = mem_rvalid & ~store_r;
                if (ret_fire_s && (ret_cnt_r == CNT_LAST)) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Captured request fields; store flag stays valid through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stride_r <= 32'd0;
            store_r  <= 1'b0;
        end else if (accept_s) begin
            stride_r <= req_stride;
            store_r  <= req_store;
        end else begin
            stride_r <= stride_r;
            store_r  <= store_r;
        end
    end

    // Issue side: the running address advances by the stride on each
    // handshake (equal to base + cnt*stride mod 2^32), and the store data
    // shifts down so the current element always sits in the low word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r      <= 32'd0;
            wdata_r     <= {(VL*SEW){1'b0}};
            issue_cnt_r <= {CW{1'b0}};
        end else if (accept_s) begin
            addr_r      <= req_base;
            wdata_r     <= req_store ? req_data : {(VL*SEW){1'b0}};
            issue_cnt_r <= {CW{1'b0}};
        end else if (issue_fire_s) begin
            addr_r      <= addr_r + stride_r;
            wdata_r     <= wdata_r >> SEW;
            issue_cnt_r <= issue_cnt_r + CNT_ONE;
        end else begin
            addr_r      <= addr_r;
            wdata_r     <= wdata_r;
            issue_cnt_r <= issue_cnt_r;
        end
    end

    // Return side: place each load return into element ret_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_cnt_r   <= {CW{1'b0}};
            resp_data_r <= {(VL*SEW){1'b0}};
        end else if (accept_s) begin
            ret_cnt_r   <= {CW{1'b0}};
        end else if (ret_fire_s) begin
            ret_cnt_r <= ret_cnt_r + CNT_ONE;
            for (int i = 0; i < VL; i++) begin
                if (ret_cnt_r == CW'(i)) begin
                    resp_data_r[i*SEW +: SEW] <= mem_rdata;
                end
            end
        end else begin
            ret_cnt_r   <= ret_cnt_r;
            resp_data_r <= resp_data_r;
        end
    end

    // Outputs decode directly from registers so they are glitch-free and
    // drop with the asynchronous reset.
    assign req_ready  = (state_r == ST_IDLE);
    assign mem_valid  = (state_r == ST_ISSUE);
    assign mem_we     = (state_r == ST_ISSUE) & store_r;
    assign mem_addr   = addr_r;
    assign mem_wdata  = wdata_r[31:0];
    assign resp_valid = (state_r == ST_RESP);
    assign resp_store = store_r;
    assign resp_data  = resp_data_r;

endmodule

// File: tb/tb_vec_lsu.sv
// Self-checking bench for vec_lsu: directed scenarios from the block's
// feature list plus randomized operations, checked against a behavioural
// model (expected addresses/data computed from base + i*stride).
module tb_vec_lsu;

    localparam int VL  = 8;
    localparam int SEW = 32;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [31:0]       req_base;
    logic [31:0]       req_stride;
    logic [VL*SEW-1:0] req_data;
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_store;
    logic [VL*SEW-1:0] resp_data;

    vec_lsu #(.VL(VL), .SEW(SEW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_base   (req_base),
        .req_stride (req_stride),
        .req_data   (req_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_store (resp_store),
        .resp_data  (resp_data)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } ret_entry_t;

    int                n_cmp = 0;
    int                n_err = 0;
    int                cyc   = 0;
    int                last_due = 0;
    ret_entry_t        ret_q[$];
    logic [31:0]       mem_init [logic [31:0]];
    logic [VL*SEW-1:0] last_load = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running edge counter used for latency and return scheduling.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [VL*SEW-1:0] got,
                             input logic [VL*SEW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory contents: explicit entries, otherwise an address-derived pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_init.exists(a)) return mem_init[a];
        return {~a[15:0], a[15:0] ^ 16'h5A3C};
    endfunction

    function automatic logic [VL*SEW-1:0] rand_vec();
        logic [VL*SEW-1:0] v;
        for (int i = 0; i < VL; i++) v[i*SEW +: SEW] = $urandom;
        return v;
    endfunction

    // Run one vector operation from IDLE to the response handshake.
    // rdy_mode: 0 = ready always, 1 = pattern 1,0,0,..., 2 = random.
    task automatic run_op(input bit st, input logic [31:0] base, input logic [31:0] stride,
                          input logic [VL*SEW-1:0] data, input int rdy_mode,
                          input int max_dly, input int hold, input bit chk_lat);
        logic [31:0]       exp_addr [VL];
        logic [VL*SEW-1:0] exp_data;
        bit                accepted, done, seen_resp, from_q;
        int                issued, rets, acc_edge, hold_left, k, due;
        ret_entry_t        e;
        accepted = 0; done = 0; seen_resp = 0;
        issued = 0; rets = 0; acc_edge = 0; hold_left = hold; k = 0;
        for (int i = 0; i < VL; i++) begin
            exp_addr[i] = base + stride * 32'(i);
            exp_data[i*SEW +: SEW] = st ? data[i*SEW +: SEW] : mem_word(exp_addr[i]);
        end
        req_valid = 1'b1; req_store = st; req_base = base; req_stride = stride;
        req_data = data; resp_ready = 1'b0;
        for (int t = 0; t < 400 && !done; t++) begin
            if (accepted) req_valid = 1'b0;
            case (rdy_mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = (k % 3 == 0);
                default: mem_ready = 1'($urandom_range(0, 1));
            endcase
            k++;
            from_q = 0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
            if (ret_q.size() > 0 && ret_q[0].due <= cyc + 1) begin
                e = ret_q.pop_front();
                mem_rvalid = 1'b1; mem_rdata = e.data; from_q = 1;
            end else if ((st || resp_valid) && $urandom_range(0, 2) == 0) begin
                mem_rvalid = 1'b1; mem_rdata = $urandom;   // must be ignored
            end
            resp_ready = 1'b0;
            if (resp_valid) begin
                if (hold_left > 0) hold_left--;
                else resp_ready = 1'b1;
            end
            #1;
            if (!accepted && req_ready) begin
                accepted = 1; acc_edge = cyc + 1;
            end
            // Address/data must always show the next unissued element,
            // which also proves they hold while stalled.
            if (mem_valid) begin
                if (issued < VL) begin
                    check_val("mem_addr", mem_addr, exp_addr[issued]);
                    check_val("mem_we", mem_we, st);
                    if (st) check_val("mem_wdata", mem_wdata, data[issued*SEW +: SEW]);
                end else begin
                    check_val("extra_issue", issued, VL - 1);
                end
                if (mem_ready) begin
                    if (!st) begin
                        due = cyc + 2 + $urandom_range(0, max_dly);
                        if (due <= last_due) due = last_due + 1;
                        last_due = due;
                        ret_q.push_back('{due, mem_word(mem_addr)});
                    end
                    issued++;
                end
            end
            if (resp_valid) begin
                if (!seen_resp) begin
                    seen_resp = 1;
                    check_val("issue_count", issued, VL);
                    if (!st) check_val("ret_count", rets, VL);
                    if (chk_lat) check_val("latency", cyc - acc_edge, st ? VL : VL + 1);
                end
                check_val("resp_store", resp_store, st);
                check_val("resp_data", resp_data, st ? last_load : exp_data);
                check_val("req_ready_busy", req_ready, 1'b0);
                if (resp_ready) done = 1;
            end
            if (from_q) rets++;
            @(posedge clk);
            @(negedge clk);
        end
        check_val("op_done", done, 1'b1);
        req_valid = 1'b0; resp_ready = 1'b0; mem_rvalid = 1'b0; mem_ready = 1'b0;
        ret_q.delete();
        if (!st) last_load = exp_data;
    endtask

    // Idle cycles with stray returns: nothing may change.
    task automatic idle_check(input int n);
        for (int t = 0; t < n; t++) begin
            mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
            #1;
            check_val("idle_req_ready", req_ready, 1'b1);
            check_val("idle_mem_valid", mem_valid, 1'b0);
            check_val("idle_resp_valid", resp_valid, 1'b0);
            check_val("idle_resp_data", resp_data, last_load);
            @(posedge clk);
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
    endtask

    // Load aborted by reset after three issue handshakes.
    task automatic reset_mid_op();
        int         issued;
        ret_entry_t e;
        issued = 0;
        req_valid = 1'b1; req_store = 1'b0; req_base = $urandom & 32'hFFFF_FFFC;
        req_stride = 32'd4; req_data = '0; mem_ready = 1'b1; resp_ready = 1'b0;
        for (int t = 0; t < 50 && issued < 3; t++) begin
            mem_rvalid = 1'b0;
            if (ret_q.size() > 0 && ret_q[0].due <= cyc + 1) begin
                e = ret_q.pop_front(); mem_rvalid = 1'b1; mem_rdata = e.data;
            end
            #1;
            if (mem_valid) begin
                issued++;
                ret_q.push_back('{cyc + 2, mem_word(mem_addr)});
            end
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
        end
        check_val("rst_pre_issued", issued, 3);
        rst_n = 1'b0;
        #1;
        check_val("rst_mem_valid", mem_valid, 1'b0);
        check_val("rst_req_ready", req_ready, 1'b1);
        check_val("rst_resp_data", resp_data, '0);
        check_val("rst_resp_valid", resp_valid, 1'b0);
        ret_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_load = '0;
        idle_check(3);
    endtask

    initial begin
        logic [VL*SEW-1:0] v;
        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_base = 32'd0;
        req_stride = 32'd0; req_data = '0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = 32'd0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_req_ready", req_ready, 1'b1);
        check_val("reset_mem_valid", mem_valid, 1'b0);
        check_val("reset_mem_we", mem_we, 1'b0);
        check_val("reset_mem_addr", mem_addr, 32'd0);
        check_val("reset_mem_wdata", mem_wdata, 32'd0);
        check_val("reset_resp_valid", resp_valid, 1'b0);
        check_val("reset_resp_store", resp_store, 1'b0);
        check_val("reset_resp_data", resp_data, '0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // Unit-stride load with fixed 1-cycle latency.
        for (int i = 0; i < VL; i++) mem_init[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
        run_op(1'b0, 32'h100, 32'd4, '0, 0, 0, 0, 1'b1);
        // Negative-stride store, elements 1..8.
        for (int i = 0; i < VL; i++) v[i*SEW +: SEW] = 32'(i + 1);
        run_op(1'b1, 32'h20, 32'hFFFF_FFFC, v, 0, 0, 0, 1'b1);
        idle_check(2);
        // Backpressure on load and store.
        run_op(1'b0, 32'h100, 32'd4, '0, 1, 0, 0, 1'b0);
        run_op(1'b1, 32'h400, 32'd8, rand_vec(), 1, 0, 0, 1'b0);
        // Variable return latency with random ready.
        run_op(1'b0, 32'h1000, 32'd12, '0, 2, 4, 0, 1'b0);
        run_op(1'b0, 32'h2000, 32'hFFFF_FFF0, '0, 0, 4, 0, 1'b0);
        // Address wrap and zero stride.
        run_op(1'b0, 32'hFFFF_FFFC, 32'd4, '0, 0, 0, 0, 1'b1);
        run_op(1'b0, 32'h0000_0300, 32'd0, '0, 2, 2, 0, 1'b0);
        run_op(1'b1, 32'h0000_0300, 32'd0, rand_vec(), 0, 0, 0, 1'b1);
        // Response stall for 5 cycles.
        run_op(1'b0, 32'h500, 32'd4, '0, 0, 1, 5, 1'b0);
        run_op(1'b1, 32'h600, 32'd4, rand_vec(), 0, 0, 5, 1'b0);
        idle_check(2);
        // Randomized operations.
        for (int n = 0; n < 24; n++) begin
            logic [31:0] b, s;
            b = $urandom & 32'hFFFF_FFFC;
            s = ($urandom_range(0, 3) == 0) ? $urandom
                                            : (32'($urandom_range(0, 32)) - 32'd16) << 2;
            run_op(1'($urandom_range(0, 1)), b, s, rand_vec(), $urandom_range(0, 2),
                   $urandom_range(0, 4), $urandom_range(0, 3), 1'b0);
            if ($urandom_range(0, 3) == 0) idle_check(1);
        end
        idle_check(2);
        // Abort by reset mid-operation, then a normal op afterwards.
        reset_mid_op();
        run_op(1'b0, 32'h100, 32'd4, '0, 0, 0, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
